// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris datapath blocks.
//   STATE_*  : top-level FSM state codes driven on the 'state' bus
//   PIECE_*  : two-bit piece codes (all pieces fit in a 2x2 box)
//   ROWS_DEF / COLS_DEF : default board geometry (8 rows x 4 columns)
//   piece_h / piece_w   : piece height / width (1 or 2) from its code
package tetris_pkg;

  localparam logic [2:0] STATE_GEN   = 3'b000;
  localparam logic [2:0] STATE_MOVE  = 3'b001;
  localparam logic [2:0] STATE_CLEAR = 3'b011;

  localparam logic [1:0] PIECE_DOT    = 2'b00;
  localparam logic [1:0] PIECE_HBAR   = 2'b01;
  localparam logic [1:0] PIECE_VBAR   = 2'b10;
  localparam logic [1:0] PIECE_SQUARE = 2'b11;

  localparam int ROWS_DEF = 8;
  localparam int COLS_DEF = 4;

  // Bit 1 of the code marks a two-row piece, bit 0 a two-column piece.
  function automatic logic [1:0] piece_h(input logic [1:0] piece);
    return piece[1] ? 2'd2 : 2'd1;
  endfunction

  function automatic logic [1:0] piece_w(input logic [1:0] piece);
    return piece[0] ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/piece_mask.sv
// Combinational piece rasteriser.
//   piece_i : piece code
//   row_i   : anchor (top-left) row
//   col_i   : anchor (top-left) column
//   mask_o  : ROWS*COLS board bitmap of the cells the piece covers;
//             cell(r,c) = bit r*COLS+c, cells outside the board are dropped
//   h_o/w_o : piece height / width
module piece_mask
  import tetris_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic [1:0]               piece_i,
  input  logic [$clog2(ROWS)-1:0]  row_i,
  input  logic [$clog2(COLS)-1:0]  col_i,
  output logic [ROWS*COLS-1:0]     mask_o,
  output logic [1:0]               h_o,
  output logic [1:0]               w_o
);

  logic [7:0] r0;
  logic [7:0] c0;
  logic [7:0] r_end;
  logic [7:0] c_end;

  assign h_o   = piece_h(piece_i);
  assign w_o   = piece_w(piece_i);
  assign r0    = 8'(row_i);
  assign c0    = 8'(col_i);
  assign r_end = r0 + 8'(h_o);
  assign c_end = c0 + 8'(w_o);

  // Each cell asks whether it lies inside the piece's bounding box; every
  // piece fills its box completely, so this is the exact shape.
  for (genvar b = 0; b < ROWS * COLS; b++) begin : g_cell
    localparam logic [7:0] R = 8'(b / COLS);
    localparam logic [7:0] C = 8'(b % COLS);
    assign mask_o[b] = (R >= r0) && (R < r_end) && (C >= c0) && (C < c_end);
  end

endmodule

// File: rtl/piece_drop.sv
// Falling-piece stage ahead of clear_redraw.
//   clka       : clock, posedge
//   restart_n  : asynchronous active-low reset
//   state      : top FSM state (GEN spawns, MOVE advances, else freeze)
//   curr_piece : piece code, sampled on spawn
//   board_in   : settled board without the falling piece
//   move_left  : level request, one column per MOVE cycle
//   move_right : level request, one column per MOVE cycle
//   board_out  : board_in with the falling piece overlaid; merged board after lock
//   piece_row  : anchor row of the falling piece
//   piece_col  : anchor column of the falling piece
//   landed     : one-cycle pulse when the piece locks
//   error      : sticky spawn-collision flag
module piece_drop
  import tetris_pkg::*;
#(
  parameter int ROWS        = ROWS_DEF,
  parameter int COLS        = COLS_DEF,
  parameter int SPAWN_COL   = 1,
  parameter int GRAVITY_DIV = 4
) (
  input  logic                     clka,
  input  logic                     restart_n,
  input  logic [2:0]               state,
  input  logic [1:0]               curr_piece,
  input  logic [ROWS*COLS-1:0]     board_in,
  input  logic                     move_left,
  input  logic                     move_right,
  output logic [ROWS*COLS-1:0]     board_out,
  output logic [$clog2(ROWS)-1:0]  piece_row,
  output logic [$clog2(COLS)-1:0]  piece_col,
  output logic                     landed,
  output logic                     error
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int N  = ROWS * COLS;
  localparam int GW = (GRAVITY_DIV > 1) ? $clog2(GRAVITY_DIV) : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FALL     = 2'd1;
  localparam logic [1:0] S_LOCKED   = 2'd2;
  localparam logic [1:0] S_GAMEOVER = 2'd3;

  logic [1:0]    fsm_q,    fsm_d;
  logic [1:0]    piece_q,  piece_d;
  logic [RW-1:0] row_q,    row_d;
  logic [CW-1:0] col_q,    col_d;
  logic [GW-1:0] cnt_q,    cnt_d;
  logic [N-1:0]  board_q,  board_d;
  logic          landed_q, landed_d;
  logic          error_q,  error_d;

  // Outside FALL the "current" rasteriser shows the would-be spawn
  // position, so the same instance serves the spawn collision check.
  logic          falling;
  logic [1:0]    cur_piece;
  logic [RW-1:0] cur_row;
  logic [CW-1:0] cur_col;

  assign falling   = (fsm_q == S_FALL);
  assign cur_piece = falling ? piece_q : curr_piece;
  assign cur_row   = falling ? row_q   : '0;
  assign cur_col   = falling ? col_q   : CW'(SPAWN_COL);

  logic [N-1:0]  mask_c, mask_l, mask_r, mask_dn, mask_lat;
  logic [1:0]    h_c, w_c, h_l, w_l, h_r, w_r, h_dn, w_dn;
  logic [CW-1:0] col_lat;

  piece_mask #(.ROWS(ROWS), .COLS(COLS)) u_mask_cur (
    .piece_i (cur_piece),
    .row_i   (cur_row),
    .col_i   (cur_col),
    .mask_o  (mask_c),
    .h_o     (h_c),
    .w_o     (w_c)
  );

  // Left/right candidates may wrap at the edges; their bounds are checked
  // before the mask is ever used.
  piece_mask #(.ROWS(ROWS), .COLS(COLS)) u_mask_left (
    .piece_i (piece_q),
    .row_i   (row_q),
    .col_i   (col_q - CW'(1)),
    .mask_o  (mask_l),
    .h_o     (h_l),
    .w_o     (w_l)
  );

  piece_mask #(.ROWS(ROWS), .COLS(COLS)) u_mask_right (
    .piece_i (piece_q),
    .row_i   (row_q),
    .col_i   (col_q + CW'(1)),
    .mask_o  (mask_r),
    .h_o     (h_r),
    .w_o     (w_r)
  );

  // Gravity tests the column chosen by this cycle's lateral move.
  piece_mask #(.ROWS(ROWS), .COLS(COLS)) u_mask_down (
    .piece_i (piece_q),
    .row_i   (row_q + RW'(1)),
    .col_i   (col_lat),
    .mask_o  (mask_dn),
    .h_o     (h_dn),
    .w_o     (w_dn)
  );

  // All instances rasterise the same piece; only the current one's size is used.
  logic unused_dims;
  assign unused_dims = ^{h_l, w_l, h_r, w_r, h_dn, w_dn};

  // Lateral move
  logic        want_l, want_r, can_l, can_r, go_l, go_r;
  logic [CW:0] col_end;

  assign want_l  = move_left & ~move_right;
  assign want_r  = move_right & ~move_left;
  assign col_end = (CW+1)'(col_q) + (CW+1)'(w_c);
  assign can_l   = (col_q != '0) && ((mask_l & board_in) == '0);
  assign can_r   = (col_end < (CW+1)'(COLS)) && ((mask_r & board_in) == '0);
  assign go_l    = want_l & can_l;
  assign go_r    = want_r & can_r;

  always_comb begin
    col_lat  = col_q;
    mask_lat = mask_c;
    if (go_l) begin
      col_lat  = col_q - CW'(1);
      mask_lat = mask_l;
    end else if (go_r) begin
      col_lat  = col_q + CW'(1);
      mask_lat = mask_r;
    end
  end

  // Gravity and lock decision
  logic        tick, at_floor, blocked, lock, spawn_hit;
  logic [RW:0] row_end;

  assign tick      = (cnt_q == GW'(GRAVITY_DIV - 1));
  assign row_end   = (RW+1)'(row_q) + (RW+1)'(h_c);
  assign at_floor  = (row_end == (RW+1)'(ROWS));
  assign blocked   = |(mask_dn & board_in);
  assign lock      = tick & (at_floor | blocked);
  assign spawn_hit = |(mask_c & board_in);

  always_comb begin
    fsm_d    = fsm_q;
    piece_d  = piece_q;
    row_d    = row_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    board_d  = board_q;
    landed_d = 1'b0;
    error_d  = error_q;
    case (fsm_q)
      S_IDLE, S_LOCKED: begin
        if (state == STATE_GEN) begin
          piece_d = curr_piece;
          row_d   = '0;
          col_d   = CW'(SPAWN_COL);
          cnt_d   = '0;
          if (spawn_hit) begin
            fsm_d   = S_GAMEOVER;
            error_d = 1'b1;
            board_d = board_in;
          end else begin
            fsm_d   = S_FALL;
            board_d = board_in | mask_c;
          end
        end
      end
      S_FALL: begin
        if (state == STATE_MOVE) begin
          col_d = col_lat;
          if (tick) begin
            cnt_d = '0;
            if (lock) begin
              fsm_d    = S_LOCKED;
              board_d  = board_in | mask_lat;
              landed_d = 1'b1;
            end else begin
              row_d   = row_q + RW'(1);
              board_d = board_in | mask_dn;
            end
          end else begin
            cnt_d   = cnt_q + GW'(1);
            board_d = board_in | mask_lat;
          end
        end else begin
          // Frozen position, but the overlay follows board_in.
          board_d = board_in | mask_c;
        end
      end
      default: ;  // GAMEOVER absorbs everything until reset
    endcase
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      fsm_q    <= S_IDLE;
      piece_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      cnt_q    <= '0;
      board_q  <= '0;
      landed_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      piece_q  <= piece_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      board_q  <= board_d;
      landed_q <= landed_d;
      error_q  <= error_d;
    end
  end

  assign board_out = board_q;
  assign piece_row = row_q;
  assign piece_col = col_q;
  assign landed    = landed_q;
  assign error     = error_q;

endmodule

// File: tb/tb_piece_drop.sv
module tb_piece_drop;
  import tetris_pkg::*;

  localparam logic [2:0] ST_IDLE = 3'b100;

  logic        clka = 1'b0;
  logic        restart_n;
  logic [2:0]  state;
  logic [1:0]  curr_piece;
  logic [31:0] board_in;
  logic        move_left, move_right;
  logic [31:0] board_out;
  logic [2:0]  piece_row;
  logic [1:0]  piece_col;
  logic        landed, error;

  int n_vec  = 0;
  int n_miss = 0;

  piece_drop dut (
    .clka       (clka),
    .restart_n  (restart_n),
    .state      (state),
    .curr_piece (curr_piece),
    .board_in   (board_in),
    .move_left  (move_left),
    .move_right (move_right),
    .board_out  (board_out),
    .piece_row  (piece_row),
    .piece_col  (piece_col),
    .landed     (landed),
    .error      (error)
  );

  always #5 clka = ~clka;

  typedef struct {
    logic [2:0]  st;
    logic [1:0]  pc;
    logic [31:0] bi;
    logic        ml;
    logic        mr;
    logic [31:0] bo;
    logic [2:0]  row;
    logic [1:0]  col;
    logic        lnd;
    logic        err;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] st, input logic [1:0] pc,
                              input logic [31:0] bi, input logic ml, input logic mr,
                              input logic [31:0] bo, input logic [2:0] row,
                              input logic [1:0] col, input logic lnd, input logic err);
    vec_t v;
    v.st = st; v.pc = pc; v.bi = bi; v.ml = ml; v.mr = mr;
    v.bo = bo; v.row = row; v.col = col; v.lnd = lnd; v.err = err;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] bo, input logic [2:0] row,
                       input logic [1:0] col, input logic lnd, input logic err);
    n_vec++;
    if (board_out !== bo || piece_row !== row || piece_col !== col ||
        landed !== lnd || error !== err) begin
      n_miss++;
      $display("FAIL %s: got bo=%h row=%0d col=%0d landed=%b error=%b, want bo=%h row=%0d col=%0d landed=%b error=%b",
               nm, board_out, piece_row, piece_col, landed, error, bo, row, col, lnd, err);
    end
  endtask

  // Drive for one cycle, then sample 1 time unit after the rising edge.
  task automatic drive(input logic [2:0] st, input logic [1:0] pc, input logic [31:0] bi,
                       input logic ml, input logic mr);
    state = st; curr_piece = pc; board_in = bi; move_left = ml; move_right = mr;
    @(posedge clka);
    #1;
  endtask

  vec_t vecs[17];

  initial begin
    // Square spawn, gravity every 4 MOVE cycles, right moves at the wall,
    // both-requests no-op, freeze under CLEAR/GEN with overlay tracking board_in.
    vecs[0]  = mk(ST_IDLE,     2'd3, 32'h0,        0, 0, 32'h0,        3'd0, 2'd0, 0, 0);
    vecs[1]  = mk(STATE_GEN,   2'd3, 32'h0,        0, 0, 32'h00000066, 3'd0, 2'd1, 0, 0);
    vecs[2]  = mk(STATE_MOVE,  2'd0, 32'h0,        0, 0, 32'h00000066, 3'd0, 2'd1, 0, 0);
    vecs[3]  = mk(STATE_MOVE,  2'd0, 32'h0,        0, 0, 32'h00000066, 3'd0, 2'd1, 0, 0);
    vecs[4]  = mk(STATE_MOVE,  2'd0, 32'h0,        0, 0, 32'h00000066, 3'd0, 2'd1, 0, 0);
    vecs[5]  = mk(STATE_MOVE,  2'd0, 32'h0,        0, 0, 32'h00000660, 3'd1, 2'd1, 0, 0);
    vecs[6]  = mk(STATE_MOVE,  2'd0, 32'h0,        0, 1, 32'h00000CC0, 3'd1, 2'd2, 0, 0);
    vecs[7]  = mk(STATE_MOVE,  2'd0, 32'h0,        0, 1, 32'h00000CC0, 3'd1, 2'd2, 0, 0);
    vecs[8]  = mk(STATE_MOVE,  2'd0, 32'h0,        1, 1, 32'h00000CC0, 3'd1, 2'd2, 0, 0);
    vecs[9]  = mk(STATE_MOVE,  2'd0, 32'h0,        0, 0, 32'h0000CC00, 3'd2, 2'd2, 0, 0);
    vecs[10] = mk(STATE_MOVE,  2'd0, 32'h0,        0, 0, 32'h0000CC00, 3'd2, 2'd2, 0, 0);
    vecs[11] = mk(STATE_MOVE,  2'd0, 32'h0,        0, 0, 32'h0000CC00, 3'd2, 2'd2, 0, 0);
    vecs[12] = mk(STATE_CLEAR, 2'd0, 32'hF0000000, 1, 0, 32'hF000CC00, 3'd2, 2'd2, 0, 0);
    vecs[13] = mk(STATE_CLEAR, 2'd0, 32'h0,        0, 0, 32'h0000CC00, 3'd2, 2'd2, 0, 0);
    vecs[14] = mk(STATE_GEN,   2'd1, 32'h0,        0, 0, 32'h0000CC00, 3'd2, 2'd2, 0, 0);
    vecs[15] = mk(STATE_MOVE,  2'd0, 32'h0,        0, 0, 32'h0000CC00, 3'd2, 2'd2, 0, 0);
    vecs[16] = mk(STATE_MOVE,  2'd0, 32'h0,        0, 0, 32'h000CC000, 3'd3, 2'd2, 0, 0);

    restart_n = 1'b0;
    state = ST_IDLE; curr_piece = 2'd0; board_in = 32'h0; move_left = 1'b0; move_right = 1'b0;
    #3;
    check("reset_state", 32'h0, 3'd0, 2'd0, 1'b0, 1'b0);
    #9 restart_n = 1'b1;  // t=12, between edges

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].st, vecs[i].pc, vecs[i].bi, vecs[i].ml, vecs[i].mr);
      check($sformatf("vec%0d", i), vecs[i].bo, vecs[i].row, vecs[i].col, vecs[i].lnd, vecs[i].err);
    end

    // Asynchronous reset mid-fall: outputs clear without a clock edge.
    #2 restart_n = 1'b0;
    #1 check("async_reset", 32'h0, 3'd0, 2'd0, 1'b0, 1'b0);
    @(posedge clka);
    #3 restart_n = 1'b1;
    #1;

    // Dot slides into the empty left column and falls to the floor.
    drive(STATE_GEN, 2'd0, 32'hEEEEEE00, 1, 0);
    check("dot_spawn", 32'hEEEEEE02, 3'd0, 2'd1, 1'b0, 1'b0);
    for (int c = 1; c <= 34; c++) begin
      logic [2:0] er;
      logic [31:0] eb;
      er = (c < 32) ? 3'(c / 4) : 3'd7;
      eb = 32'hEEEEEE00 | (32'h1 << (4 * int'(er)));
      drive(STATE_MOVE, 2'd0, 32'hEEEEEE00, 1, 0);
      check($sformatf("dot_fall%0d", c), eb, er, 2'd0, (c == 32), 1'b0);
    end
    // Locked board ignores board_in until the next spawn.
    drive(STATE_MOVE, 2'd0, 32'h0, 0, 0);
    check("locked_hold", 32'hFEEEEE00, 3'd7, 2'd0, 1'b0, 1'b0);

    // Spawn collision from LOCKED: game over, sticky.
    drive(STATE_GEN, 2'd3, 32'h00000006, 0, 0);
    check("gameover", 32'h00000006, 3'd0, 2'd1, 1'b0, 1'b1);
    drive(STATE_MOVE, 2'd0, 32'h00000006, 0, 0);
    check("gameover_move", 32'h00000006, 3'd0, 2'd1, 1'b0, 1'b1);
    drive(STATE_MOVE, 2'd0, 32'h00000006, 0, 0);
    check("gameover_move2", 32'h00000006, 3'd0, 2'd1, 1'b0, 1'b1);
    drive(STATE_GEN, 2'd0, 32'h0, 0, 0);
    check("gameover_regen", 32'h00000006, 3'd0, 2'd1, 1'b0, 1'b1);

    #2 restart_n = 1'b0;
    #1 check("error_cleared", 32'h0, 3'd0, 2'd0, 1'b0, 1'b0);
    #2 restart_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
